// File: rtl/dma_copy_ctrl.sv
// Byte-copy sequencer: streams len bytes from src to dst through a one-cycle-latency memory,
// choosing copy direction so overlapping regions behave like memmove.
module dma_copy_ctrl #(
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  len,
  output logic              busy,
  output logic              done,
  output logic              mem_rd_valid,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [7:0]        mem_rd_data,
  output logic              mem_wr_valid,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [7:0]        mem_wr_data
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t            r_state;
  logic              r_desc;
  logic [LEN_W-1:0]  r_remain;
  logic [ADDR_W-1:0] r_dst_nxt;
  logic              r_busy;
  logic              r_done;
  logic              r_rd_valid;
  logic [ADDR_W-1:0] r_rd_addr;
  logic              r_wr_valid;
  logic [ADDR_W-1:0] r_wr_addr;

  logic [ADDR_W:0]   w_src_ext;
  logic [ADDR_W:0]   w_dst_ext;
  logic [ADDR_W:0]   w_src_end;
  logic              w_desc;
  logic [ADDR_W-1:0] w_len_ext;
  logic [ADDR_W-1:0] w_src_first;
  logic [ADDR_W-1:0] w_dst_first;
  logic [ADDR_W-1:0] w_step;

  // Overlap test is done one bit wider so src+len cannot wrap inside the compare.
  assign w_src_ext   = {1'b0, src_addr};
  assign w_dst_ext   = {1'b0, dst_addr};
  assign w_src_end   = w_src_ext + (ADDR_W+1)'(len);
  assign w_desc      = (w_dst_ext > w_src_ext) && (w_dst_ext < w_src_end);
  assign w_len_ext   = ADDR_W'(len);
  assign w_src_first = w_desc ? (src_addr + w_len_ext - ADDR_W'(1)) : src_addr;
  assign w_dst_first = w_desc ? (dst_addr + w_len_ext - ADDR_W'(1)) : dst_addr;
  assign w_step      = r_desc ? {ADDR_W{1'b1}} : ADDR_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_desc     <= 1'b0;
      r_remain   <= '0;
      r_dst_nxt  <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_rd_valid <= 1'b0;
      r_rd_addr  <= '0;
      r_wr_valid <= 1'b0;
      r_wr_addr  <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          r_done     <= 1'b0;
          r_wr_valid <= 1'b0;
          if (start) begin
            if (len == '0) begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_desc     <= w_desc;
              r_remain   <= len;
              r_rd_addr  <= w_src_first;
              r_dst_nxt  <= w_dst_first;
              r_rd_valid <= 1'b1;
              r_busy     <= 1'b1;
              r_state    <= S_RUN;
            end
          end
        end
        S_RUN: begin
          // Write side trails the read by one cycle, matching the memory read latency.
          r_wr_valid <= 1'b1;
          r_wr_addr  <= r_dst_nxt;
          r_dst_nxt  <= r_dst_nxt + w_step;
          r_rd_addr  <= r_rd_addr + w_step;
          r_remain   <= r_remain - LEN_W'(1);
          if (r_remain == LEN_W'(1)) begin
            r_rd_valid <= 1'b0;
            r_state    <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          r_wr_valid <= 1'b0;
          r_busy     <= 1'b0;
          r_done     <= 1'b1;
          r_state    <= S_DONE;
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy         = r_busy;
  assign done         = r_done;
  assign mem_rd_valid = r_rd_valid;
  assign mem_rd_addr  = r_rd_addr;
  assign mem_wr_valid = r_wr_valid;
  assign mem_wr_addr  = r_wr_addr;
  assign mem_wr_data  = mem_rd_data;

endmodule

// File: tb/tb_dma_copy_ctrl.sv
// Directed bench for dma_copy_ctrl: table of copy descriptors with expected addresses/timing,
// plus hand sequences for zero length and reset mid-copy.
module tb_dma_copy_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] src_addr = '0;
  logic [31:0] dst_addr = '0;
  logic [15:0] len = '0;
  logic        busy, done, mem_rd_valid, mem_wr_valid;
  logic [31:0] mem_rd_addr, mem_wr_addr;
  logic [7:0]  mem_rd_data, mem_wr_data;

  dma_copy_ctrl #(.ADDR_W(32), .LEN_W(16)) dut (
    .clk(clk), .rst(rst), .start(start),
    .src_addr(src_addr), .dst_addr(dst_addr), .len(len),
    .busy(busy), .done(done),
    .mem_rd_valid(mem_rd_valid), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .mem_wr_valid(mem_wr_valid), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data)
  );

  always #5 clk = ~clk;

  // 256-byte memory model indexed by the low address byte; one-cycle read latency.
  logic [7:0] mem [256];
  logic [7:0] snap [256];
  logic       fill_en = 1'b0;
  logic       ld_en = 1'b0;
  logic [7:0] ld_addr = '0;
  logic [7:0] ld_data = '0;

  always @(posedge clk) begin
    if (mem_rd_valid) mem_rd_data <= mem[mem_rd_addr[7:0]];
    if (fill_en) for (int i = 0; i < 256; i++) mem[i] <= 8'hEE;
    if (mem_wr_valid) mem[mem_wr_addr[7:0]] <= mem_wr_data;
    if (ld_en) mem[ld_addr] <= ld_data;
  end

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic load_byte(input logic [7:0] a, input logic [7:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic take_snap();
    for (int i = 0; i < 256; i++) snap[i] = mem[i];
  endtask

  typedef struct {
    logic [31:0] src;
    logic [31:0] dst;
    logic [15:0] len;
    logic [7:0]  base;
    logic        desc;
    logic [31:0] rd0;
    logic [31:0] wr0;
    int          inject;
  } vec_t;

  vec_t vt [8];

  task automatic run_copy(input vec_t v, input string tag);
    logic [31:0] step, ra, wa, t;
    int n;
    n = int'(v.len);
    step = v.desc ? 32'hFFFF_FFFF : 32'd1;
    for (int i = 0; i < n; i++) begin
      t = v.src + 32'(i);
      load_byte(t[7:0], v.base + 8'(i));
    end
    take_snap();
    src_addr = v.src; dst_addr = v.dst; len = v.len; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ra = v.rd0;
    wa = v.wr0;
    for (int c = 1; c <= n + 3; c++) begin
      check({tag, "_rdv"},  {31'b0, mem_rd_valid}, {31'b0, (c <= n)});
      check({tag, "_wrv"},  {31'b0, mem_wr_valid}, {31'b0, (c >= 2 && c <= n + 1)});
      check({tag, "_busy"}, {31'b0, busy},         {31'b0, (c <= n + 1)});
      check({tag, "_done"}, {31'b0, done},         {31'b0, (c == n + 2)});
      if (c <= n) begin
        check({tag, "_rdaddr"}, mem_rd_addr, ra);
        ra = ra + step;
      end
      if (c >= 2 && c <= n + 1) begin
        check({tag, "_wraddr"}, mem_wr_addr, wa);
        wa = wa + step;
      end
      if (c == v.inject) begin
        start = 1'b1; src_addr = 32'hC0; dst_addr = 32'hD0; len = 16'd2;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    for (int i = 0; i < n; i++) begin
      t = v.dst + 32'(i);
      check({tag, "_mem"}, {24'b0, mem[t[7:0]]}, {24'b0, v.base + 8'(i)});
    end
    t = v.dst - 32'd1;
    check({tag, "_below"}, {24'b0, mem[t[7:0]]}, {24'b0, snap[t[7:0]]});
    t = v.dst + 32'(n);
    check({tag, "_above"}, {24'b0, mem[t[7:0]]}, {24'b0, snap[t[7:0]]});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int diff;
    //           src           dst          len    base   desc  rd0           wr0          inject
    vt[0] = '{32'h10,       32'h40,       16'd8, 8'hA0, 1'b0, 32'h10,       32'h40,       0};
    vt[1] = '{32'h20,       32'h23,       16'd8, 8'h00, 1'b1, 32'h27,       32'h2A,       0};
    vt[2] = '{32'h30,       32'h2E,       16'd8, 8'h00, 1'b0, 32'h30,       32'h2E,       0};
    vt[3] = '{32'h50,       32'h60,       16'd1, 8'h5A, 1'b0, 32'h50,       32'h60,       0};
    vt[4] = '{32'h70,       32'h70,       16'd4, 8'h11, 1'b0, 32'h70,       32'h70,       0};
    vt[5] = '{32'h80,       32'h84,       16'd4, 8'h33, 1'b0, 32'h80,       32'h84,       0};
    vt[6] = '{32'hFFFF_FFFE, 32'h90,      16'd4, 8'h61, 1'b0, 32'hFFFF_FFFE, 32'h90,       0};
    vt[7] = '{32'h18,       32'h48,       16'd8, 8'hB0, 1'b0, 32'h18,       32'h48,       3};

    @(negedge clk);
    check("rst_busy",   {31'b0, busy},         32'd0);
    check("rst_done",   {31'b0, done},         32'd0);
    check("rst_rdv",    {31'b0, mem_rd_valid}, 32'd0);
    check("rst_wrv",    {31'b0, mem_wr_valid}, 32'd0);
    check("rst_rdaddr", mem_rd_addr,           32'd0);
    check("rst_wraddr", mem_wr_addr,           32'd0);
    fill_en = 1'b1;
    @(negedge clk);
    fill_en = 1'b0;
    rst = 1'b0;
    @(negedge clk);

    for (int k = 0; k < 8; k++) run_copy(vt[k], $sformatf("vec%0d", k));

    // Zero length: immediate done, no memory traffic.
    take_snap();
    src_addr = 32'h10; dst_addr = 32'h40; len = 16'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("zero_done_c1", {31'b0, done},         32'd1);
    check("zero_busy_c1", {31'b0, busy},         32'd0);
    check("zero_rdv_c1",  {31'b0, mem_rd_valid}, 32'd0);
    check("zero_wrv_c1",  {31'b0, mem_wr_valid}, 32'd0);
    @(negedge clk);
    check("zero_done_c2", {31'b0, done},         32'd0);
    check("zero_busy_c2", {31'b0, busy},         32'd0);
    check("zero_rdv_c2",  {31'b0, mem_rd_valid}, 32'd0);
    check("zero_wrv_c2",  {31'b0, mem_wr_valid}, 32'd0);
    diff = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== snap[i]) diff++;
    check("zero_mem_diff", 32'(diff), 32'd0);

    // Reset in cycle 4 of a len=8 copy into 0xA0: only the cycle 2 and 3 writes land.
    src_addr = 32'h10; dst_addr = 32'hA0; len = 16'd8; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_busy",   {31'b0, busy},         32'd0);
    check("mid_rst_done",   {31'b0, done},         32'd0);
    check("mid_rst_rdv",    {31'b0, mem_rd_valid}, 32'd0);
    check("mid_rst_wrv",    {31'b0, mem_wr_valid}, 32'd0);
    check("mid_rst_rdaddr", mem_rd_addr,           32'd0);
    check("mid_rst_wraddr", mem_wr_addr,           32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("post_rst_done", {31'b0, done}, 32'd0);
      check("post_rst_busy", {31'b0, busy}, 32'd0);
    end
    check("rst_mem_a0", {24'b0, mem[8'hA0]}, 32'hA0);
    check("rst_mem_a1", {24'b0, mem[8'hA1]}, 32'hA1);
    for (int i = 2; i < 8; i++) check("rst_mem_untouched", {24'b0, mem[8'hA0 + 8'(i)]}, 32'hEE);

    run_copy(vt[3], "after_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
